adc128s022_responder: RTL and testbench
=======================================

Name: adc128s022_responder

Overview:
- Synthesizable emulator of the ADC128S022 serial interface (SPI responder side); the counterpart of the ADC-reading master.
- Samples adc_sclk / adc_cs_n / adc_saddr with an oversampling system clock, decodes the 3-bit channel address and shifts 12-bit channel data out on adc_sdat.
- Used for FPGA loopback tests and for simulating the DE0-Nano ADC path without the real ADC.
- Channel values come from a flat parallel input bus.

Parameters:
DATA_WIDTH, 12, conversion result width; frame fixed at 16 bits, so 4 leading zeros + 12 data bits
ADC_SELECT_WIDTH, 3, channel address width
NUM_CH, 8, number of emulated channels (2**ADC_SELECT_WIDTH)
SYNC_STAGES, 2, synchronizer flops on each SPI input

Ports:
clk_ad  input  1  system clock; must be >= 8x adc_sclk frequency
rst  input  1  asynchronous, active-high reset
ch_data  input  NUM_CH*DATA_WIDTH  channel n value at [n*12 +: 12]
adc_sclk  input  1  serial clock from master; idles high
adc_cs_n  input  1  chip select, active low
adc_saddr  input  1  address bit from master (DIN)
adc_sdat  output  1  serial data to master (DOUT)
sdat_oe  output  1  high while adc_cs_n is (synchronized) low
frame_done  output  1  one-clk_ad pulse when a full 16-bit frame completes
frame_ch  output  3  channel whose data was sent in the completed frame
frame_addr  output  3  address received in the completed frame

Behaviour:
- Reset values (async on rst high): adc_sdat=0, sdat_oe=0, frame_done=0, frame_ch=0, frame_addr=0.
- Reset values for internal state: next_ch=0, rise_cnt=0, shift=0, addr=0, synchronizers=idle (sclk=1, cs_n=1).
- Input conditioning:
  - adc_sclk, adc_cs_n and adc_saddr each pass through SYNC_STAGES flops.
  - A further flop on sclk and cs_n provides edge detect.
  - Every event below acts on a single-cycle detected edge.
- State machine: IDLE, ACTIVE.
- IDLE:
  - sdat_oe=0, adc_sdat=0.
  - On cs_n fall: load shift={4'b0, ch_data[next_ch]}, cur_ch=next_ch, rise_cnt=0, sdat_oe=1, go to ACTIVE.
- ACTIVE, sclk fall:
  - If rise_cnt!=0, shift left by 1.
  - If rise_cnt==0, no shift (first fall of a frame).
- ACTIVE, adc_sdat: always shift[15], registered.
- ACTIVE, sclk rise: rise_cnt+=1.
  - On rises 3, 4 and 5 (rise_cnt 2, 3, 4 before increment), capture synchronized saddr into addr[2], addr[1], addr[0].
- ACTIVE, 16th rise (rise_cnt==15):
  - frame_done=1 for one cycle; frame_ch=cur_ch; frame_addr=addr (using the bit captured this cycle if rise 5 coincides, not possible for 16).
  - next_ch=addr; rise_cnt=0.
  - Reload shift={4'b0, ch_data[addr]}; cur_ch=addr.
  - This supports back-to-back frames with cs_n held low.
- Conversion pipeline (datasheet semantics):
  - The data in frame k is the channel addressed in frame k-1.
  - The first frame after reset converts channel 0.
  - next_ch persists across cs_n high periods.
- Track-and-hold: ch_data is sampled only at load time. Changes during a frame do not affect the bits in flight.
- Master samples on sclk rise: rise n carries bit 16-n (rises 1–4 = 0, rises 5–16 = data MSB..LSB).
- Latency:
  - adc_sdat updates SYNC_STAGES+2 clk_ad cycles after the pin-level sclk fall.
  - This is within half an sclk period at the >=8x ratio.
- cs_n rise in ACTIVE (any rise_cnt, including mid-frame):
  - Go to IDLE; sdat_oe=0, adc_sdat=0.
  - No frame_done; next_ch unchanged; partial addr discarded.
- cs_n rise in the same cycle as the 16th rise: the frame completes (frame_done, next_ch update), then go to IDLE.
- sclk edges while in IDLE: ignored.
- rst mid-frame: immediate return to IDLE with all reset values; next_ch returns to 0.

Test Plan:
- Reset check: after rst, with ch_data[0]=12'hABC, run one frame with address 3'b101. Expect bits on rises 1..16 = 0000_1010_1011_1100; frame_done pulse; frame_ch=0; frame_addr=5.
- Pipeline across CS toggle: continue from the reset check with ch_data[5]=12'h123 and a new frame addressing ch 2. Expect data 12'h123, frame_ch=5, frame_addr=2; next frame yields ch_data[2].
- Back-to-back with cs_n held low for 48 sclk cycles, addresses 1, 6, 7. Expect three frame_done pulses with frame_ch=prev, 1, 6; no lost or duplicated bit at frame boundaries.
- Abort: raise cs_n after rise 9. Expect sdat_oe=0, adc_sdat=0 and no frame_done. Next frame still sends the channel held in next_ch, and the partial address is ignored.
- Track-and-hold: change ch_data[cur_ch] from 12'hFFF to 12'h000 after rise 6. Remaining bits still come from 12'hFFF.
- Async reset: assert rst mid-frame (after rise 7). Expect outputs 0 within the same cycle. The following frame outputs ch_data[0].

Source files
------------

// File: rtl/adc128s022_responder.sv
// ADC128S022 serial-interface emulator (responder side): decodes the channel address
// from the master and returns the previously addressed channel's 12-bit value.
module adc128s022_responder #(
  parameter int DATA_WIDTH       = 12,
  parameter int ADC_SELECT_WIDTH = 3,
  parameter int NUM_CH           = 2**ADC_SELECT_WIDTH,
  parameter int SYNC_STAGES      = 2
) (
  input  logic                           clk_ad,
  input  logic                           rst,
  input  logic [NUM_CH*DATA_WIDTH-1:0]   ch_data,
  input  logic                           adc_sclk,
  input  logic                           adc_cs_n,
  input  logic                           adc_saddr,
  output logic                           adc_sdat,
  output logic                           sdat_oe,
  output logic                           frame_done,
  output logic [ADC_SELECT_WIDTH-1:0]    frame_ch,
  output logic [ADC_SELECT_WIDTH-1:0]    frame_addr
);

  localparam int FRAME_BITS      = 16;
  localparam int LEAD_ZEROS      = FRAME_BITS - DATA_WIDTH;
  localparam int CNT_W           = $clog2(FRAME_BITS);
  // Zero-based rise count of the first address bit (rise 3 of the frame).
  localparam int ADDR_FIRST_RISE = 2;

  typedef enum logic {ST_IDLE, ST_ACTIVE} state_e;

  function automatic logic [FRAME_BITS-1:0] frame_word(
    input logic [NUM_CH*DATA_WIDTH-1:0] data,
    input logic [ADC_SELECT_WIDTH-1:0]  sel
  );
    return {{LEAD_ZEROS{1'b0}}, data[int'(sel)*DATA_WIDTH +: DATA_WIDTH]};
  endfunction

  // Input conditioning
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_n_sync_q, saddr_sync_q;
  logic                   sclk_prev_q, cs_n_prev_q;
  logic                   sclk_s, cs_n_s, saddr_s;
  logic                   sclk_rise, sclk_fall, cs_fall, cs_rise;

  // NOTE: the synchronizers reset to the bus idle levels (sclk and cs_n high) so
  // that leaving reset can never be mistaken for a falling edge.
  always_ff @(posedge clk_ad or posedge rst) begin
    if (rst) begin
      sclk_sync_q  <= '1;
      cs_n_sync_q  <= '1;
      saddr_sync_q <= '0;
      sclk_prev_q  <= 1'b1;
      cs_n_prev_q  <= 1'b1;
    end else begin
      sclk_sync_q  <= SYNC_STAGES'({sclk_sync_q, adc_sclk});
      cs_n_sync_q  <= SYNC_STAGES'({cs_n_sync_q, adc_cs_n});
      saddr_sync_q <= SYNC_STAGES'({saddr_sync_q, adc_saddr});
      sclk_prev_q  <= sclk_s;
      cs_n_prev_q  <= cs_n_s;
    end
  end

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_n_s    = cs_n_sync_q[SYNC_STAGES-1];
  assign saddr_s   = saddr_sync_q[SYNC_STAGES-1];
  assign sclk_rise = ~sclk_prev_q & sclk_s;
  assign sclk_fall = sclk_prev_q & ~sclk_s;
  assign cs_fall   = cs_n_prev_q & ~cs_n_s;
  assign cs_rise   = ~cs_n_prev_q & cs_n_s;

  // FSM and datapath registers
  state_e                        state_q, state_d;
  logic [FRAME_BITS-1:0]         shift_q, shift_d;
  logic [CNT_W-1:0]              rise_cnt_q, rise_cnt_d;
  logic [ADC_SELECT_WIDTH-1:0]   addr_q, addr_d;
  logic [ADC_SELECT_WIDTH-1:0]   cur_ch_q, cur_ch_d;
  logic [ADC_SELECT_WIDTH-1:0]   next_ch_q, next_ch_d;
  logic                          adc_sdat_q, adc_sdat_d;
  logic                          sdat_oe_q, sdat_oe_d;
  logic                          frame_done_q, frame_done_d;
  logic [ADC_SELECT_WIDTH-1:0]   frame_ch_q, frame_ch_d;
  logic [ADC_SELECT_WIDTH-1:0]   frame_addr_q, frame_addr_d;
  logic [ADC_SELECT_WIDTH-1:0]   addr_cap;
  logic                          frame_end;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk_ad or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (cs_fall) state_d = ST_ACTIVE;
      ST_ACTIVE: if (cs_rise) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  assign frame_end = (state_q == ST_ACTIVE) && sclk_rise &&
                     (rise_cnt_q == CNT_W'(FRAME_BITS - 1));

  // Address bits arrive MSB first; the bit sampled this cycle must be visible
  // to the frame-completion logic in the same cycle.
  always_comb begin
    addr_cap = addr_q;
    if (state_q == ST_ACTIVE && sclk_rise) begin
      for (int b = 0; b < ADC_SELECT_WIDTH; b++) begin
        if (rise_cnt_q == CNT_W'(ADDR_FIRST_RISE + ADC_SELECT_WIDTH - 1 - b)) begin
          addr_cap[b] = saddr_s;
        end
      end
    end
  end

  // NOTE: every signal assigned in a combinational block gets a default first,
  // so no path can leave it unassigned and infer a latch.
  always_comb begin
    shift_d    = shift_q;
    rise_cnt_d = rise_cnt_q;
    addr_d     = addr_q;
    cur_ch_d   = cur_ch_q;
    next_ch_d  = next_ch_q;
    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          shift_d    = frame_word(ch_data, next_ch_q);
          cur_ch_d   = next_ch_q;
          rise_cnt_d = '0;
          addr_d     = '0;
        end
      end
      ST_ACTIVE: begin
        // The first fall of a frame presents the already-loaded MSB.
        if (sclk_fall && rise_cnt_q != '0) begin
          shift_d = shift_q << 1;
        end
        if (sclk_rise) begin
          rise_cnt_d = rise_cnt_q + 1'b1;
          addr_d     = addr_cap;
        end
        if (frame_end) begin
          next_ch_d  = addr_cap;
          rise_cnt_d = '0;
          shift_d    = frame_word(ch_data, addr_cap);
          cur_ch_d   = addr_cap;
        end else if (cs_rise) begin
          addr_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    adc_sdat_d   = 1'b0;
    sdat_oe_d    = (state_d == ST_ACTIVE);
    frame_done_d = 1'b0;
    frame_ch_d   = frame_ch_q;
    frame_addr_d = frame_addr_q;
    if (state_q == ST_ACTIVE && state_d == ST_ACTIVE) begin
      adc_sdat_d = shift_q[FRAME_BITS-1];
    end
    if (frame_end) begin
      frame_done_d = 1'b1;
      frame_ch_d   = cur_ch_q;
      frame_addr_d = addr_cap;
    end
  end

  always_ff @(posedge clk_ad or posedge rst) begin
    if (rst) begin
      shift_q      <= '0;
      rise_cnt_q   <= '0;
      addr_q       <= '0;
      cur_ch_q     <= '0;
      next_ch_q    <= '0;
      adc_sdat_q   <= 1'b0;
      sdat_oe_q    <= 1'b0;
      frame_done_q <= 1'b0;
      frame_ch_q   <= '0;
      frame_addr_q <= '0;
    end else begin
      shift_q      <= shift_d;
      rise_cnt_q   <= rise_cnt_d;
      addr_q       <= addr_d;
      cur_ch_q     <= cur_ch_d;
      next_ch_q    <= next_ch_d;
      adc_sdat_q   <= adc_sdat_d;
      sdat_oe_q    <= sdat_oe_d;
      frame_done_q <= frame_done_d;
      frame_ch_q   <= frame_ch_d;
      frame_addr_q <= frame_addr_d;
    end
  end

  assign adc_sdat   = adc_sdat_q;
  assign sdat_oe    = sdat_oe_q;
  assign frame_done = frame_done_q;
  assign frame_ch   = frame_ch_q;
  assign frame_addr = frame_addr_q;

endmodule

// File: tb/tb_adc128s022_responder.sv
// Bench for adc128s022_responder: acts as the SPI master and scores returned frames
// and frame_done reports against a small conversion-pipeline model.
module tb_adc128s022_responder;

  localparam int DW   = 12;
  localparam int AW   = 3;
  localparam int NCH  = 8;
  localparam int HALF = 8;  // clk_ad cycles per sclk half period (16x ratio)

  logic                clk_ad = 1'b0;
  logic                rst;
  logic [NCH*DW-1:0]   ch_data;
  logic                adc_sclk, adc_cs_n, adc_saddr;
  logic                adc_sdat, sdat_oe, frame_done;
  logic [AW-1:0]       frame_ch, frame_addr;

  logic [DW-1:0]       ch_vals [NCH];
  logic [15:0]         data_q [$];
  logic [5:0]          done_q [$];
  logic [AW-1:0]       model_next;
  int                  n_checks = 0;
  int                  n_pass   = 0;

  always #5 clk_ad = ~clk_ad;

  for (genvar g = 0; g < NCH; g++) begin : g_pack
    assign ch_data[g*DW +: DW] = ch_vals[g];
  end

  adc128s022_responder dut (
    .clk_ad     (clk_ad),
    .rst        (rst),
    .ch_data    (ch_data),
    .adc_sclk   (adc_sclk),
    .adc_cs_n   (adc_cs_n),
    .adc_saddr  (adc_saddr),
    .adc_sdat   (adc_sdat),
    .sdat_oe    (sdat_oe),
    .frame_done (frame_done),
    .frame_ch   (frame_ch),
    .frame_addr (frame_addr)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // frame_done reports are popped from the scoreboard as they appear.
  always @(negedge clk_ad) begin
    logic [5:0] e;
    if (frame_done === 1'b1) begin
      if (done_q.size() == 0) begin
        check("done_unexpected", 32'(frame_done), 32'd0);
      end else begin
        e = done_q.pop_front();
        check("frame_ch", 32'(frame_ch), 32'(e[5:3]));
        check("frame_addr", 32'(frame_addr), 32'(e[2:0]));
      end
    end
  end

  // One frame of n_rises sclk cycles; optionally rewrites the converting channel
  // after rise hook_rise. Lowers cs_n first if it is high.
  task automatic frame(input logic [2:0] addr, input int n_rises,
                       input int hook_rise, input logic [DW-1:0] hook_val);
    logic [15:0] got, exp_word, mask;
    logic [2:0]  cur;
    cur = model_next;
    data_q.push_back({4'h0, ch_vals[cur]});
    if (n_rises == 16) begin
      done_q.push_back({cur, addr});
      model_next = addr;
    end
    if (adc_cs_n) begin
      adc_cs_n = 1'b0;
      repeat (HALF) @(negedge clk_ad);
    end
    got = '0;
    for (int n = 1; n <= n_rises; n++) begin
      adc_sclk  = 1'b0;
      adc_saddr = (n == 3) ? addr[2] : (n == 4) ? addr[1] : (n == 5) ? addr[0] : 1'b0;
      repeat (HALF) @(negedge clk_ad);
      if (n == 1) check("sdat_oe_active", 32'(sdat_oe), 32'd1);
      got[16-n] = adc_sdat;
      adc_sclk  = 1'b1;
      repeat (HALF) @(negedge clk_ad);
      if (n == hook_rise) ch_vals[cur] = hook_val;
    end
    mask     = ~(16'hFFFF >> n_rises);
    exp_word = data_q.pop_front();
    check("frame_bits", 32'(got & mask), 32'(exp_word & mask));
    if (n_rises == 16) check("done_pending", done_q.size(), 32'd0);
  endtask

  task automatic cs_high();
    adc_cs_n = 1'b1;
    repeat (2*HALF) @(negedge clk_ad);
    check("sdat_oe_idle", 32'(sdat_oe), 32'd0);
    check("sdat_idle", 32'(adc_sdat), 32'd0);
  endtask

  task automatic idle_sclk(input int n);
    for (int i = 0; i < n; i++) begin
      adc_sclk  = 1'b0;
      adc_saddr = 1'($urandom_range(0, 1));
      repeat (HALF) @(negedge clk_ad);
      adc_sclk  = 1'b1;
      repeat (HALF) @(negedge clk_ad);
    end
    check("sdat_oe_idle_sclk", 32'(sdat_oe), 32'd0);
  endtask

  initial begin
    rst       = 1'b1;
    adc_sclk  = 1'b1;
    adc_cs_n  = 1'b1;
    adc_saddr = 1'b0;
    model_next = '0;
    ch_vals[0] = 12'hABC; ch_vals[1] = 12'h5A5; ch_vals[2] = 12'h2D4; ch_vals[3] = 12'h0F0;
    ch_vals[4] = 12'hF0F; ch_vals[5] = 12'h123; ch_vals[6] = 12'hC3C; ch_vals[7] = 12'h7E1;
    repeat (4) @(negedge clk_ad);
    rst = 1'b0;
    repeat (4) @(negedge clk_ad);

    check("rst_sdat", 32'(adc_sdat), 32'd0);
    check("rst_oe", 32'(sdat_oe), 32'd0);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_frame_ch", 32'(frame_ch), 32'd0);
    check("rst_frame_addr", 32'(frame_addr), 32'd0);

    // First frame after reset converts channel 0
    frame(3'd5, 16, 0, '0);
    cs_high();
    idle_sclk(3);

    // Pipeline across a cs_n toggle
    frame(3'd2, 16, 0, '0);
    cs_high();

    // Back-to-back frames with cs_n held low
    frame(3'd1, 16, 0, '0);
    frame(3'd6, 16, 0, '0);
    frame(3'd7, 16, 0, '0);
    cs_high();
    frame(3'd0, 16, 0, '0);
    cs_high();

    // Abort after rise 9: partial address discarded, next_ch kept
    frame(3'd3, 9, 0, '0);
    cs_high();
    frame(3'd4, 16, 0, '0);
    cs_high();

    // Track-and-hold: the converting channel changes mid-frame
    ch_vals[4] = 12'hFFF;
    frame(3'd1, 16, 6, 12'h000);
    cs_high();

    // Asynchronous reset after rise 7
    ch_vals[1] = 12'hFFF;
    frame(3'd2, 7, 0, '0);
    rst = 1'b1;
    #1;
    check("mid_rst_sdat", 32'(adc_sdat), 32'd0);
    check("mid_rst_oe", 32'(sdat_oe), 32'd0);
    check("mid_rst_frame_ch", 32'(frame_ch), 32'd0);
    check("mid_rst_frame_addr", 32'(frame_addr), 32'd0);
    adc_cs_n = 1'b1;
    adc_sclk = 1'b1;
    repeat (4) @(negedge clk_ad);
    rst = 1'b0;
    model_next = '0;
    ch_vals[0] = 12'h3C9;
    repeat (HALF) @(negedge clk_ad);
    frame(3'd2, 16, 0, '0);
    cs_high();

    check("done_queue_empty", done_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
